pipelined_alu_param: RTL and testbench
======================================

# pipelined_alu_param

Parametrised successor to the fixed 16-bit pipelined ALU: a 3-stage execute pipeline with configurable data width and a request tag carried through the pipeline. Full valid/ready handshaking on both sides supports stalls and backpressure. The opcode set adds variable shifts, arithmetic shift, and unsigned min/max, and illegal opcodes are reported. It sits between an operand/issue source and a result consumer, at one result per cycle when not stalled.

## Interface
- WIDTH, 16, datapath width; power of two, minimum 4
- TAG_W, 4, width of the opaque request tag returned with each result
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  stage 1 can accept; transfer when in_valid && in_ready
- in_a, in_b  in  WIDTH  operands
- in_op  in  4  opcode
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- out_result  out  WIDTH  result
- out_z, out_c, out_v, out_n  out  1 each  zero, carry/borrow, signed overflow, negative flags
- out_err  out  1  illegal opcode
- out_tag  out  TAG_W  tag of this result

## Operation
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~A
  - 6 SHL: A << B[SW-1:0]
  - 7 SHR: logical right shift
  - 8 SRA: arithmetic right shift
  - 9 CMP: 1 if A==B, else 2 if A>B unsigned, else 0
  - 10 MINU: unsigned minimum
  - 11 MAXU: unsigned maximum
  - 12–15: illegal
- SW = clog2(WIDTH). B bits above SW are ignored for shifts. Shift amount 0 passes A unchanged.
- All arithmetic is WIDTH bits modulo 2^WIDTH. The carry is bit WIDTH of a (WIDTH+1)-bit sum.
- Flags:
  - Z = (result == 0). N = result[WIDTH-1].
  - C:
    - ADD: carry out.
    - SUB: borrow, i.e. 1 when A < B unsigned.
    - SHL: last bit shifted out, A[WIDTH-amt].
    - SHR/SRA: A[amt-1].
    - Shift amount 0, or any other opcode: C = 0.
  - V:
    - ADD: A[msb]==B[msb] && R[msb]!=A[msb].
    - SUB: A[msb]!=B[msb] && R[msb]!=A[msb].
    - Any other opcode: V = 0.
  - All flags are computed from the same-beat result. There is no one-cycle flag skew.
- Illegal opcode: result 0, out_err=1, Z=C=V=N=0.
- Tag is passed unmodified alongside its beat.
- Beats are never dropped, duplicated or reordered.

## Timing
- Stages:
  - S1 registers operands, opcode and tag.
  - S2 registers the execute result plus flags, err and tag.
  - S3 is the output register and drives out_*.
- Each stage k has a valid bit vk. Stage readiness:
  - rdy3 = !v3 || out_ready
  - rdy2 = !v2 || rdy3
  - rdy1 = !v1 || rdy2
  - in_ready = rdy1
- Stage k loads from stage k−1 when rdyk; otherwise it holds its contents.
- The ready chain is combinational from out_ready to in_ready. Reaching full throughput needs no skid buffer.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+2, i.e. 3 register stages, when unstalled.
- Throughput: 1 beat per cycle with out_ready held high.
- Stall: while out_valid && !out_ready, all out_* hold stable. Upstream stages fill, and in_ready falls once v1=v2=v3=1.
- Full pipeline with simultaneous accept and release: every stage advances in the same cycle, and in_ready stays 1.
- Empty pipeline: in_ready=1 regardless of out_ready.
- Reset (rst_n=0, asynchronous, at any time including mid-stall):
  - v1=v2=v3=0, so out_valid=0.
  - out_result=0, all flags=0, out_err=0, out_tag=0.
  - in_ready=1 after release.
  - In-flight beats are discarded.
- Data registers need not be reset, except the S3 output register, which is reset to 0.

## Structure
- Package alu_pkg:
  - opcode enum OP_ADD…OP_MAXU
  - OP_W=4
  - illegal-opcode range constant
- Sub-module alu_exec: purely combinational.
  - Inputs: a, b, op. Outputs: result, z, c, v, n, err. Parametrised by WIDTH.
  - Instantiated between S1 and S2.
- Top module: valid/ready control and the three register stages.

## Test plan
- WIDTH=16, out_ready=1. ADD 0xFFFF+0x0001 tag 3 → after 3 cycles result 0x0000, Z=1, C=1, V=0, N=0, tag 3.
- SUB 0x8000−0x0001 → 0x7FFF, V=1, C=0, N=0. SUB 0x0001−0x0002 → 0xFFFF, C=1, N=1, V=0.
- Shifts:
  - SHL 0x8001 by B=1 → 0x0002, C=1.
  - SRA 0x8000 by B=0x0013 (amount 3) → 0xF000, C=0.
  - SHR by 0 → A, C=0.
- Backpressure: stream 8 beats with tags 0–7 while out_ready is low for 5 cycles. Check in_ready drops after 3 accepts, out_* stay stable while stalled, and all 8 results emerge in order with no loss or duplication.
- Illegal op 13 → result 0, out_err=1, flags 0. CMP 5 vs 5 → 1; 7 vs 5 → 2; 5 vs 7 → 0.
- Assert rst_n low mid-stall with 3 beats in flight → out_valid=0 immediately (asynchronous). After release the pipeline is empty and no stale beat is emitted. Repeat at WIDTH=32 for the ADD and shift cases.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the parametrised pipelined ALU.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SRA  = 4'd8,
    OP_CMP  = 4'd9,
    OP_MINU = 4'd10,
    OP_MAXU = 4'd11
  } op_e;

  // Every encoding from here to the top of the opcode space is reported as illegal.
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd12;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational execute stage: computes result and Z/C/V/N/err for one beat.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] amt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic [WIDTH:0] sra_ext;

  // Shifts run on a one-bit-wider vector so the last bit shifted out lands in a fixed slot.
  always_comb begin
    amt     = b[SW-1:0];
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    shl_ext = {1'b0, a} << amt;
    shr_ext = {a, 1'b0} >> amt;
    sra_ext = $signed({a, 1'b0}) >>> amt;

    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    err    = op_is_illegal(op);

    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL: begin
        result = shl_ext[WIDTH-1:0];
        c      = shl_ext[WIDTH];
      end
      OP_SHR: begin
        result = shr_ext[WIDTH:1];
        c      = shr_ext[0];
      end
      OP_SRA: begin
        result = sra_ext[WIDTH:1];
        c      = sra_ext[0];
      end
      OP_CMP: begin
        if (a == b) begin
          result = WIDTH'(1);
        end else if (a > b) begin
          result = WIDTH'(2);
        end
      end
      OP_MINU: result = (a < b) ? a : b;
      OP_MAXU: result = (a > b) ? a : b;
      default: ;
    endcase

    z = !err && (result == '0);
    n = result[WIDTH-1];
  end

endmodule

// File: rtl/pipelined_alu_param.sv
// Three-stage valid/ready ALU pipeline: operand register, execute register, output register.
module pipelined_alu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic             out_n,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  logic             rdy1, rdy2, rdy3;

  logic             vld1_q, vld1_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [OP_W-1:0]  op1_q, op1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic [WIDTH-1:0] ex_result;
  logic             ex_z, ex_c, ex_v, ex_n, ex_err;

  logic             vld2_q, vld2_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic [3:0]       flg2_q, flg2_d;
  logic             err2_q, err2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             vld3_q, vld3_d;
  logic [WIDTH-1:0] res3_q, res3_d;
  logic [3:0]       flg3_q, flg3_d;
  logic             err3_q, err3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  alu_exec #(.WIDTH(WIDTH)) u_exec (
    .a      (a1_q),
    .b      (b1_q),
    .op     (op1_q),
    .result (ex_result),
    .z      (ex_z),
    .c      (ex_c),
    .v      (ex_v),
    .n      (ex_n),
    .err    (ex_err)
  );

  // A stage can take a new beat if it is empty or the stage after it is moving.
  always_comb begin
    rdy3     = !vld3_q || out_ready;
    rdy2     = !vld2_q || rdy3;
    rdy1     = !vld1_q || rdy2;
    in_ready = rdy1;
  end

  always_comb begin
    vld1_d = vld1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    op1_d  = op1_q;
    tag1_d = tag1_q;
    vld2_d = vld2_q;
    res2_d = res2_q;
    flg2_d = flg2_q;
    err2_d = err2_q;
    tag2_d = tag2_q;
    vld3_d = vld3_q;
    res3_d = res3_q;
    flg3_d = flg3_q;
    err3_d = err3_q;
    tag3_d = tag3_q;

    if (rdy1) begin
      vld1_d = in_valid;
      if (in_valid) begin
        a1_d   = in_a;
        b1_d   = in_b;
        op1_d  = in_op;
        tag1_d = in_tag;
      end
    end

    if (rdy2) begin
      vld2_d = vld1_q;
      if (vld1_q) begin
        res2_d = ex_result;
        flg2_d = {ex_z, ex_c, ex_v, ex_n};
        err2_d = ex_err;
        tag2_d = tag1_q;
      end
    end

    // Payload only changes when a real beat arrives, so the outputs stay put across bubbles.
    if (rdy3) begin
      vld3_d = vld2_q;
      if (vld2_q) begin
        res3_d = res2_q;
        flg3_d = flg2_q;
        err3_d = err2_q;
        tag3_d = tag2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      op1_q  <= '0;
      tag1_q <= '0;
      vld2_q <= 1'b0;
      res2_q <= '0;
      flg2_q <= '0;
      err2_q <= 1'b0;
      tag2_q <= '0;
      vld3_q <= 1'b0;
      res3_q <= '0;
      flg3_q <= '0;
      err3_q <= 1'b0;
      tag3_q <= '0;
    end else begin
      vld1_q <= vld1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      op1_q  <= op1_d;
      tag1_q <= tag1_d;
      vld2_q <= vld2_d;
      res2_q <= res2_d;
      flg2_q <= flg2_d;
      err2_q <= err2_d;
      tag2_q <= tag2_d;
      vld3_q <= vld3_d;
      res3_q <= res3_d;
      flg3_q <= flg3_d;
      err3_q <= err3_d;
      tag3_q <= tag3_d;
    end
  end

  assign out_valid  = vld3_q;
  assign out_result = res3_q;
  assign out_z      = flg3_q[3];
  assign out_c      = flg3_q[2];
  assign out_v      = flg3_q[1];
  assign out_n      = flg3_q[0];
  assign out_err    = err3_q;
  assign out_tag    = tag3_q;

endmodule

// File: tb/tb_pipelined_alu_param.sv
// Self-checking bench for pipelined_alu_param at WIDTH=16 and WIDTH=32 against an arithmetic reference model.
module tb_pipelined_alu_param;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [3:0]  tag;
    logic [31:0] r;
    logic [4:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  op16, tag16, otag16;
  logic        z16, c16, v16, n16, e16;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  op32, tag32, otag32;
  logic        z32, c32, v32, n32, e32;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipelined_alu_param #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_op(op16), .in_tag(tag16),
    .out_valid(ov16), .out_ready(or16), .out_result(res16),
    .out_z(z16), .out_c(c16), .out_v(v16), .out_n(n16), .out_err(e16), .out_tag(otag16)
  );

  pipelined_alu_param #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32), .in_op(op32), .in_tag(tag32),
    .out_valid(ov32), .out_ready(or32), .out_result(res32),
    .out_z(z32), .out_c(c32), .out_v(v32), .out_n(n32), .out_err(e32), .out_tag(otag32)
  );

  // Reference model in plain integer arithmetic; f = {err, z, c, v, n}.
  function automatic void model(input int w, input longint a, input longint b, input int op,
                                output longint r, output logic [4:0] f);
    longint mask, half, sa, sb, s;
    int amt;
    logic err, c, v;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    amt = int'(b % w);
    r = 0; c = 0; v = 0; err = 0;
    case (op)
      0: begin s = a + b; r = s & mask; c = (s > mask); v = ((sa + sb) >= half) || ((sa + sb) < -half); end
      1: begin r = (a - b) & mask; c = (a < b); v = ((sa - sb) >= half) || ((sa - sb) < -half); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & mask;
      6: begin r = (a << amt) & mask; c = (amt != 0) && (((a >> (w - amt)) & 1) == 1); end
      7: begin r = a >> amt; c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1); end
      8: begin r = (sa >>> amt) & mask; c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1); end
      9: r = (a == b) ? 1 : ((a > b) ? 2 : 0);
      10: r = (a < b) ? a : b;
      11: r = (a > b) ? a : b;
      default: err = 1;
    endcase
    f = {err, (r == 0) && !err, c, v, ((r >> (w - 1)) & 1) == 1};
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Sends one beat into an empty pipeline with out_ready high and returns what emerges.
  task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic [3:0] tag,
                               output logic [31:0] r, output logic [4:0] f,
                               output logic [3:0] t, output int lat);
    if (wide) begin
      a32 = a; b32 = b; op32 = op; tag32 = tag; iv32 = 1'b1; or32 = 1'b1;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; op16 = op; tag16 = tag; iv16 = 1'b1; or16 = 1'b1;
    end
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    lat = 1;
    while (!(wide ? ov32 : ov16) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (wide) begin
      r = res32; f = {e32, z32, c32, v32, n32}; t = otag32;
    end else begin
      r = {16'h0, res16}; f = {e16, z16, c16, v16, n16}; t = otag16;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({ov16, res16, e16, z16, c16, v16, n16, otag16, ir16} !== {1'b0, 16'h0, 5'b0, 4'h0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset16: got valid=%b res=%h flags=%b tag=%h in_ready=%b want 0/0000/00000/0/1",
               ov16, res16, {e16, z16, c16, v16, n16}, otag16, ir16);
    end
    total++;
    if ({ov32, res32, e32, z32, c32, v32, n32, otag32, ir32} !== {1'b0, 32'h0, 5'b0, 4'h0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset32: got valid=%b res=%h flags=%b tag=%h in_ready=%b want 0/0/00000/0/1",
               ov32, res32, {e32, z32, c32, v32, n32}, otag32, ir32);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input bit wide, input vec_t tbl[]);
    logic [31:0] r;
    logic [4:0] f;
    logic [3:0] t;
    int lat;
    foreach (tbl[i]) begin
      applyStimulus(wide, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, r, f, t, lat);
      total++;
      if (r !== tbl[i].r || f !== tbl[i].f || t !== tbl[i].tag || lat != 3) begin
        bad++;
        $display("[TB] FAIL %s[%0d]: got r=%h f=%b tag=%h lat=%0d want r=%h f=%b tag=%h lat=3",
                 name, i, r, f, t, lat, tbl[i].r, tbl[i].f, tbl[i].tag);
      end
    end
  endtask

  task automatic test_arith();
    vec_t tbl[];
    tbl = new[5];
    tbl[0] = '{32'hFFFF, 32'h0001, 4'd0, 4'd3, 32'h0000, 5'b01100};
    tbl[1] = '{32'h8000, 32'h0001, 4'd1, 4'd5, 32'h7FFF, 5'b00010};
    tbl[2] = '{32'h0001, 32'h0002, 4'd1, 4'd6, 32'hFFFF, 5'b00101};
    tbl[3] = '{32'h7FFF, 32'h0001, 4'd0, 4'd7, 32'h8000, 5'b00011};
    tbl[4] = '{32'h00FF, 32'h1234, 4'd5, 4'd8, 32'hFF00, 5'b00001};
    run_table("arith16", 1'b0, tbl);
  endtask

  task automatic test_shift();
    vec_t tbl[];
    tbl = new[5];
    tbl[0] = '{32'h8001, 32'h0001, 4'd6, 4'd1, 32'h0002, 5'b00100};
    tbl[1] = '{32'h8000, 32'h0013, 4'd8, 4'd2, 32'hF000, 5'b00001};
    tbl[2] = '{32'hA5A5, 32'h0010, 4'd7, 4'd3, 32'hA5A5, 5'b00001};
    tbl[3] = '{32'hC001, 32'h000F, 4'd7, 4'd4, 32'h0001, 5'b00100};
    tbl[4] = '{32'h0001, 32'h000F, 4'd6, 4'd5, 32'h8000, 5'b00001};
    run_table("shift16", 1'b0, tbl);
  endtask

  task automatic test_logic_cmp_illegal();
    vec_t tbl[];
    tbl = new[10];
    tbl[0] = '{32'h1234, 32'h5678, 4'd13, 4'd9, 32'h0000, 5'b10000};
    tbl[1] = '{32'h0000, 32'h0000, 4'd15, 4'hA, 32'h0000, 5'b10000};
    tbl[2] = '{32'h0005, 32'h0005, 4'd9, 4'hB, 32'h0001, 5'b00000};
    tbl[3] = '{32'h0007, 32'h0005, 4'd9, 4'hC, 32'h0002, 5'b00000};
    tbl[4] = '{32'h0005, 32'h0007, 4'd9, 4'hD, 32'h0000, 5'b01000};
    tbl[5] = '{32'h0003, 32'h0009, 4'd10, 4'hE, 32'h0003, 5'b00000};
    tbl[6] = '{32'h8000, 32'h7FFF, 4'd11, 4'hF, 32'h8000, 5'b00001};
    tbl[7] = '{32'hF0F0, 32'h0FF0, 4'd2, 4'h0, 32'h00F0, 5'b00000};
    tbl[8] = '{32'hAAAA, 32'hAAAA, 4'd4, 4'h1, 32'h0000, 5'b01000};
    tbl[9] = '{32'h1200, 32'h0034, 4'd3, 4'h2, 32'h1234, 5'b00000};
    run_table("misc16", 1'b0, tbl);
  endtask

  task automatic test_wide();
    vec_t tbl[];
    logic [31:0] a, b, r;
    logic [4:0] f, mf;
    logic [3:0] op, t;
    longint mr;
    int lat;
    tbl = new[6];
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 4'd0, 4'd3, 32'h00000000, 5'b01100};
    tbl[1] = '{32'h80000001, 32'h00000001, 4'd6, 4'd4, 32'h00000002, 5'b00100};
    tbl[2] = '{32'h80000000, 32'h00000023, 4'd8, 4'd5, 32'hF0000000, 5'b00001};
    tbl[3] = '{32'h12345678, 32'h00000020, 4'd7, 4'd6, 32'h12345678, 5'b00000};
    tbl[4] = '{32'h80000000, 32'h00000001, 4'd1, 4'd7, 32'h7FFFFFFF, 5'b00010};
    tbl[5] = '{32'h80000000, 32'h0000001F, 4'd7, 4'd8, 32'h00000001, 5'b00000};
    run_table("wide32", 1'b1, tbl);
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
      applyStimulus(1'b1, a, b, op, 4'(i), r, f, t, lat);
      model(32, longint'(a), longint'(b), int'(op), mr, mf);
      total++;
      if (r !== mr[31:0] || f !== mf || t !== 4'(i) || lat != 3) begin
        bad++;
        $display("[TB] FAIL rand32 op=%0d a=%h b=%h: got r=%h f=%b tag=%h lat=%0d want r=%h f=%b tag=%h lat=3",
                 op, a, b, r, f, t, lat, mr[31:0], mf, 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] qr[$];
    logic [4:0] qf[$];
    logic [3:0] qt[$];
    logic [15:0] er;
    logic [4:0] ef, mf;
    logic [3:0] et;
    longint mr;
    int rcv = 0;
    for (int k = 0; k < 13; k++) begin
      iv16 = (k < 10);
      a16 = pick16(); b16 = pick16(); op16 = 4'($urandom_range(0, 11)); tag16 = 4'(k);
      or16 = 1'b1;
      @(negedge clk);
      total++;
      if (ir16 !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_in_ready cycle %0d: got %b want 1", k, ir16);
      end
      if (ov16) begin
        total++;
        if (qr.size() == 0) begin
          bad++;
          $display("[TB] FAIL b2b_extra: got unexpected beat tag=%h want none", otag16);
        end else begin
          er = qr.pop_front(); ef = qf.pop_front(); et = qt.pop_front();
          if ({res16, e16, z16, c16, v16, n16, otag16} !== {er, ef, et}) begin
            bad++;
            $display("[TB] FAIL b2b_data: got r=%h f=%b tag=%h want r=%h f=%b tag=%h",
                     res16, {e16, z16, c16, v16, n16}, otag16, er, ef, et);
          end
        end
        rcv++;
      end
      if (iv16 && ir16) begin
        model(16, longint'(a16), longint'(b16), int'(op16), mr, mf);
        qr.push_back(mr[15:0]); qf.push_back(mf); qt.push_back(tag16);
      end
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    total++;
    if (rcv != 10) begin
      bad++;
      $display("[TB] FAIL b2b_count: got %0d beats within 13 cycles want 10", rcv);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] qr[$];
    logic [4:0] qf[$];
    logic [3:0] qt[$];
    logic [15:0] ba[8];
    logic [15:0] bb[8];
    logic [3:0] bo[8];
    logic [15:0] er;
    logic [4:0] ef, mf;
    logic [3:0] et;
    logic [25:0] prev = '0;
    longint mr;
    int cyc = 0, sent = 0, rcv = 0;
    bit prev_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ba[i] = pick16(); bb[i] = pick16(); bo[i] = 4'($urandom_range(0, 11));
    end
    while (rcv < 8 && cyc < 60) begin
      iv16 = (sent < 8);
      a16 = ba[sent & 7]; b16 = bb[sent & 7]; op16 = bo[sent & 7]; tag16 = 4'(sent);
      or16 = (cyc >= 5);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if ({ov16, res16, e16, z16, c16, v16, n16, otag16} !== prev) begin
          bad++;
          $display("[TB] FAIL bp_stable cycle %0d: got %h want %h", cyc,
                   {ov16, res16, e16, z16, c16, v16, n16, otag16}, prev);
        end
      end
      if (cyc == 3) begin
        total++;
        if (ir16 !== 1'b0 || sent != 3) begin
          bad++;
          $display("[TB] FAIL bp_full: got in_ready=%b accepts=%0d want 0 and 3", ir16, sent);
        end
      end
      if (ov16 && or16) begin
        total++;
        if (qr.size() == 0) begin
          bad++;
          $display("[TB] FAIL bp_extra: got unexpected beat tag=%h want none", otag16);
        end else begin
          er = qr.pop_front(); ef = qf.pop_front(); et = qt.pop_front();
          if ({res16, e16, z16, c16, v16, n16, otag16} !== {er, ef, et}) begin
            bad++;
            $display("[TB] FAIL bp_data: got r=%h f=%b tag=%h want r=%h f=%b tag=%h",
                     res16, {e16, z16, c16, v16, n16}, otag16, er, ef, et);
          end
        end
        rcv++;
      end
      if (iv16 && ir16) begin
        model(16, longint'(a16), longint'(b16), int'(op16), mr, mf);
        qr.push_back(mr[15:0]); qf.push_back(mf); qt.push_back(tag16);
        sent++;
      end
      prev_stall = ov16 && !or16;
      prev = {ov16, res16, e16, z16, c16, v16, n16, otag16};
      @(posedge clk); #1;
      cyc++;
    end
    iv16 = 1'b0; or16 = 1'b1;
    total++;
    if (rcv != 8 || qr.size() != 0) begin
      bad++;
      $display("[TB] FAIL bp_count: got %0d beats (%0d pending) want 8 (0 pending)", rcv, qr.size());
    end
  endtask

  task automatic test_random_stream();
    localparam int N = 150;
    logic [15:0] qr[$];
    logic [4:0] qf[$];
    logic [3:0] qt[$];
    logic [15:0] er;
    logic [4:0] ef, mf;
    logic [3:0] et;
    logic [25:0] prev = '0;
    longint mr;
    int cyc = 0, sent = 0, rcv = 0;
    bit prev_stall = 1'b0;
    bit acc = 1'b1;
    iv16 = 1'b0;
    while ((sent < N || rcv < N) && cyc < 3000) begin
      if (acc || !iv16) begin
        iv16 = (sent < N) && ($urandom_range(0, 3) != 0);
        a16 = pick16(); b16 = pick16(); op16 = 4'($urandom_range(0, 15)); tag16 = 4'($urandom);
      end
      or16 = (sent >= N) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if ({ov16, res16, e16, z16, c16, v16, n16, otag16} !== prev) begin
          bad++;
          $display("[TB] FAIL rnd_stable cycle %0d: got %h want %h", cyc,
                   {ov16, res16, e16, z16, c16, v16, n16, otag16}, prev);
        end
      end
      if (ov16 && or16) begin
        total++;
        if (qr.size() == 0) begin
          bad++;
          $display("[TB] FAIL rnd_extra: got unexpected beat tag=%h want none", otag16);
        end else begin
          er = qr.pop_front(); ef = qf.pop_front(); et = qt.pop_front();
          if ({res16, e16, z16, c16, v16, n16, otag16} !== {er, ef, et}) begin
            bad++;
            $display("[TB] FAIL rnd_data beat %0d: got r=%h f=%b tag=%h want r=%h f=%b tag=%h",
                     rcv, res16, {e16, z16, c16, v16, n16}, otag16, er, ef, et);
          end
        end
        rcv++;
      end
      acc = iv16 && ir16;
      if (acc) begin
        model(16, longint'(a16), longint'(b16), int'(op16), mr, mf);
        qr.push_back(mr[15:0]); qf.push_back(mf); qt.push_back(tag16);
        sent++;
      end
      prev_stall = ov16 && !or16;
      prev = {ov16, res16, e16, z16, c16, v16, n16, otag16};
      @(posedge clk); #1;
      cyc++;
    end
    iv16 = 1'b0; or16 = 1'b1;
    total++;
    if (rcv != N || qr.size() != 0) begin
      bad++;
      $display("[TB] FAIL rnd_count: got %0d beats (%0d pending) want %0d (0 pending)", rcv, qr.size(), N);
    end
    @(negedge clk);
    total++;
    if (ov16 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rnd_drain: got out_valid=%b after drain want 0", ov16);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstall();
    logic [31:0] r;
    logic [4:0] f;
    logic [3:0] t;
    int lat;
    bit stale = 1'b0;
    or16 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv16 = 1'b1; a16 = 16'(k + 1); b16 = 16'h0010; op16 = 4'd0; tag16 = 4'(k + 9);
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    total++;
    if (ov16 !== 1'b1 || ir16 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_prefill: got out_valid=%b in_ready=%b want 1 and 0", ov16, ir16);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ov16, res16, e16, z16, c16, v16, n16, otag16, ir16} !== {1'b0, 16'h0, 5'b0, 4'h0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL rst_async: got valid=%b res=%h flags=%b tag=%h in_ready=%b want 0/0000/00000/0/1",
               ov16, res16, {e16, z16, c16, v16, n16}, otag16, ir16);
    end
    #1 rst_n = 1'b1;
    or16 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov16 !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("[TB] FAIL rst_stale: got a beat after reset want none");
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0002, 32'h0003, 4'd0, 4'h4, r, f, t, lat);
    total++;
    if (r !== 32'h5 || f !== 5'b00000 || t !== 4'h4 || lat != 3) begin
      bad++;
      $display("[TB] FAIL rst_recover: got r=%h f=%b tag=%h lat=%0d want r=5 f=00000 tag=4 lat=3", r, f, t, lat);
    end
  endtask

  task automatic checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; tag16 = '0; or16 = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; tag32 = '0; or32 = 1'b0;
    test_reset();
    test_arith();
    test_shift();
    test_logic_cmp_illegal();
    test_wide();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_midstall();
    checkOutput();
    $finish;
  end

endmodule
